// File: rtl/uart_byte_rx.sv
// ============================================================================
//  Module   : uart_byte_rx
//  Purpose  : 8N1 UART receiver, LSB first. Synchronises the raw serial pin,
//             qualifies the start bit at its centre, samples eight data bits
//             and the stop bit at bit centres, and emits one-cycle result
//             pulses.
//  Ports    : i_clk        - system clock, rising edge
//             i_rst_n      - asynchronous active-low reset
//             uart_rx      - raw serial line, idle high, asynchronous
//             valid        - one-cycle pulse, data holds a new good byte
//             data[7:0]    - last good byte, updated only with valid
//             framing_err  - one-cycle pulse, stop bit sampled low
//             busy         - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       uart_rx,
    output logic       valid,
    output logic [7:0] data,
    output logic       framing_err,
    output logic       busy
);

    localparam int             CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic             rx_meta_q;
    logic             rx_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // LSB arrives first, so each new bit enters at the top and moves down.
    assign shift_d = {rx_s_q, shift_q[7:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == C_HALF_LAST) begin
                        cnt_q <= '0;
                        // Line back high at start-bit centre is a glitch.
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == C_BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == C_BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line must go high before a new start counts.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign valid       = valid_q;
    assign data        = data_q;
    assign framing_err = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// ============================================================================
//  Module   : tb_uart_byte_rx
//  Purpose  : Self-checking bench for uart_byte_rx. Each transmitted frame
//             records its start-edge cycle and expected outcome in a queue;
//             a per-cycle compare process matches result pulses, latency and
//             the held data byte against that expectation.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_byte_rx;

    localparam int CPB = 16;
    localparam int LAT = 154;   // nominal start-edge to result latency

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       valid;
    logic       framing_err;
    logic       busy;
    logic [7:0] data;

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .uart_rx     (rx),
        .valid       (valid),
        .data        (data),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         fall;
        bit         good;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare_loop();
        bit pv = 1'b0;
        bit pf = 1'b0;
        bit overdue;
        int lat;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_data = 8'h00;
                pv = 1'b0;
                pf = 1'b0;
                check("reset_outputs", {21'd0, valid, framing_err, busy, data}, 32'h0);
            end else begin
                check("valid_ferr_exclusive", {31'd0, valid & framing_err}, 32'h0);
                check("no_back_to_back_pulse", {31'd0, (valid & pv) | (framing_err & pf)}, 32'h0);
                if (valid || framing_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {30'd0, valid, framing_err}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", {30'd0, valid, framing_err},
                              e.good ? 32'h2 : 32'h1);
                        lat = cyc - e.fall;
                        tests++;
                        if (lat < LAT - 1 || lat > LAT + 1) begin
                            fails++;
                            $display("FAIL latency: got %0d required %0d+/-1", lat, LAT);
                        end
                        if (e.good) model_data = e.b;
                    end
                end
                overdue = !(valid || framing_err) && (exp_q.size() > 0) &&
                          (cyc > exp_q[0].fall + LAT + 1);
                check("overdue_event", {31'd0, overdue}, 32'h0);
                if (overdue) void'(exp_q.pop_front());
                check("data_hold", {24'd0, data}, {24'd0, model_data});
                pv = valid;
                pf = framing_err;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        tick(n * CPB);
    endtask

    // Leaves the line at the stop level; caller restores high after a bad stop.
    task automatic send_frame(input logic [7:0] b, input bit good);
        ev_t e;
        e.fall = cyc;
        e.good = good;
        e.b    = b;
        exp_q.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = good;
        tick(CPB);
    endtask

    logic [7:0] led [8] = '{8'h4C, 8'h45, 8'h44, 8'h31, 8'h20, 8'h4F, 8'h4E, 8'h0A};
    logic [7:0] cut_byte;
    bit         saw_busy;

    initial begin
        fork
            compare_loop();
            begin
                #5_000_000;
                $display("FAIL watchdog: got timeout required completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset with the line toggling.
        tick(1);
        for (int i = 0; i < 10; i++) begin
            rx = ~rx;
            tick(1);
        end
        check("rst_valid", {31'd0, valid}, 32'h0);
        check("rst_ferr",  {31'd0, framing_err}, 32'h0);
        check("rst_busy",  {31'd0, busy}, 32'h0);
        check("rst_data",  {24'd0, data}, 32'h0);
        rx    = 1'b1;
        rst_n = 1'b1;
        idle_bits(2);

        // Single byte 'L'.
        send_frame(8'h4C, 1'b1);
        idle_bits(2);
        check("L_data", {24'd0, data}, 32'h4C);

        // Start glitch of 3 cycles.
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy) saw_busy = 1'b1;
            tick(1);
        end
        check("glitch_busy_pulse", {31'd0, saw_busy}, 32'h1);
        check("glitch_busy_clear", {31'd0, busy}, 32'h0);
        idle_bits(1);

        // Bad stop followed by a long break.
        send_frame(8'h00, 1'b0);
        tick(20 * CPB);
        check("break_busy_high", {31'd0, busy}, 32'h1);
        tick(20 * CPB);
        check("break_data_kept", {24'd0, data}, 32'h4C);
        rx = 1'b1;
        tick(4);
        check("break_busy_clear", {31'd0, busy}, 32'h0);
        idle_bits(1);
        send_frame(8'h0A, 1'b1);
        idle_bits(2);
        check("after_break_data", {24'd0, data}, 32'h0A);

        // "LED1 ON\n" with no idle gap.
        for (int i = 0; i < 8; i++) send_frame(led[i], 1'b1);
        idle_bits(2);
        check("led_all_seen", exp_q.size(), 32'h0);
        check("led_last_data", {24'd0, data}, 32'h0A);

        // Reset during data bit 4.
        cut_byte = 8'hA7;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = cut_byte[i];
            tick(CPB);
        end
        rx = cut_byte[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(4);
        rst_n = 1'b1;
        idle_bits(2);
        check("cut_busy_clear", {31'd0, busy}, 32'h0);
        send_frame(8'h35, 1'b1);
        idle_bits(2);
        check("after_cut_data", {24'd0, data}, 32'h35);

        // Randomised frames, gaps, bad stops and glitches.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            bit         good;
            if ($urandom_range(0, 9) == 0) begin
                rx = 1'b0;
                tick($urandom_range(1, 5));
                rx = 1'b1;
                tick(CPB);
            end
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            if (!good) begin
                tick($urandom_range(0, 3) * CPB);
                idle_bits(1 + $urandom_range(0, 1));
            end else begin
                idle_bits($urandom_range(0, 2));
            end
        end
        idle_bits(4);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
